// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit.
// Holds the FSM state enum, opcode and funct constants, ALUControl codes
// and the ALUOp encoding passed from the FSM to the ALU decoder.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecute  = 4'd6,
        StAluWb    = 4'd7,
        StBranch   = 4'd8,
        StAddiEx   = 4'd9,
        StAddiWb   = 4'd10,
        StJump     = 4'd11
    } state_e;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // ALUControl codes
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        AluOpAdd   = 2'b00,
        AluOpSub   = 2'b01,
        AluOpFunct = 2'b10
    } alu_op_e;

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps ALUOp and the R-type funct field to ALUControl.
// Ports:
//   alu_op        - operation class requested by the FSM (add/sub/funct)
//   funct         - instr[5:0]
//   alu_control   - ALU operation select
//   funct_illegal - high when alu_op selects funct and funct is unsupported
module alu_decoder
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned FUNCT_WIDTH      = 6,
    parameter int unsigned ALUControl_WIDTH = 3
) (
    input  alu_op_e                     alu_op,
    input  logic [FUNCT_WIDTH-1:0]      funct,
    output logic [ALUControl_WIDTH-1:0] alu_control,
    output logic                        funct_illegal
);

    always_comb begin
        alu_control   = ALU_ADD;
        funct_illegal = 1'b0;
        unique case (alu_op)
            AluOpAdd: alu_control = ALU_ADD;
            AluOpSub: alu_control = ALU_SUB;
            AluOpFunct: begin
                case (funct)
                    FUNCT_ADD: alu_control = ALU_ADD;
                    FUNCT_SUB: alu_control = ALU_SUB;
                    FUNCT_AND: alu_control = ALU_AND;
                    FUNCT_OR:  alu_control = ALU_OR;
                    FUNCT_SLT: alu_control = ALU_SLT;
                    default:   funct_illegal = 1'b1;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore control FSM for a multicycle 32-bit MIPS datapath with a shared
// ALU and unified memory. Memory steps wait on Mem_Ready.
// Ports:
//   CLK, RST          - clock and synchronous active-high reset
//   Opcode, Funct     - fields of the instruction register
//   Zero_flag         - ALU zero flag (branch decision)
//   Mem_Ready         - memory completes the current access this cycle
//   Mem_Req, IorD, MemWrite, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB,
//   ALUControl, RegDst, MemtoReg, RegWrite - datapath controls
//   Illegal_Instr     - one-cycle pulse on unsupported opcode/funct
module multicycle_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_WIDTH     = 6,
    parameter int unsigned FUNCT_WIDTH      = 6,
    parameter int unsigned ALUControl_WIDTH = 3
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [OPCODE_WIDTH-1:0]     Opcode,
    input  logic [FUNCT_WIDTH-1:0]      Funct,
    input  logic                        Zero_flag,
    input  logic                        Mem_Ready,
    output logic                        Mem_Req,
    output logic                        IorD,
    output logic                        MemWrite,
    output logic                        IRWrite,
    output logic                        PCEn,
    output logic [1:0]                  PCSrc,
    output logic                        ALUSrcA,
    output logic [1:0]                  ALUSrcB,
    output logic [ALUControl_WIDTH-1:0] ALUControl,
    output logic                        RegDst,
    output logic                        MemtoReg,
    output logic                        RegWrite,
    output logic                        Illegal_Instr
);

    state_e                        state_q, state_d;
    alu_op_e                       alu_op;
    logic [ALUControl_WIDTH-1:0]   dec_alu_control;
    logic                          funct_illegal;
    logic                          pc_write;
    logic                          branch;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // ALUOp depends on state only, kept apart from the FSM block so the
    // decoder's funct_illegal feedback does not form a false loop.
    always_comb begin
        alu_op = AluOpAdd;
        unique case (state_q)
            StExecute: alu_op = AluOpFunct;
            StBranch:  alu_op = AluOpSub;
            default:   alu_op = AluOpAdd;
        endcase
    end

    alu_decoder #(
        .FUNCT_WIDTH      (FUNCT_WIDTH),
        .ALUControl_WIDTH (ALUControl_WIDTH)
    ) u_alu_decoder (
        .alu_op        (alu_op),
        .funct         (Funct),
        .alu_control   (dec_alu_control),
        .funct_illegal (funct_illegal)
    );

    always_comb begin
        state_d       = state_q;
        Mem_Req       = 1'b0;
        IorD          = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        PCSrc         = 2'b00;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ALUControl    = dec_alu_control;
        RegDst        = 1'b0;
        MemtoReg      = 1'b0;
        RegWrite      = 1'b0;
        Illegal_Instr = 1'b0;
        pc_write      = 1'b0;
        branch        = 1'b0;

        unique case (state_q)
            StFetch: begin
                Mem_Req  = 1'b1;
                ALUSrcB  = 2'b01;
                IRWrite  = Mem_Ready;
                pc_write = Mem_Ready;
                if (Mem_Ready) state_d = StDecode;
            end
            StDecode: begin
                // Branch target computed speculatively into ALUOut.
                ALUSrcB = 2'b11;
                case (Opcode)
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_RTYPE:     state_d = StExecute;
                    OP_BEQ:       state_d = StBranch;
                    OP_ADDI:      state_d = StAddiEx;
                    OP_J:         state_d = StJump;
                    default: begin
                        Illegal_Instr = 1'b1;
                        state_d       = StFetch;
                    end
                endcase
            end
            StMemAdr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (Opcode == OP_SW) ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                Mem_Req = 1'b1;
                IorD    = 1'b1;
                if (Mem_Ready) state_d = StMemWb;
            end
            StMemWb: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                state_d  = StFetch;
            end
            StMemWrite: begin
                // Strobe held through the whole stall.
                Mem_Req  = 1'b1;
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (Mem_Ready) state_d = StFetch;
            end
            StExecute: begin
                ALUSrcA = 1'b1;
                if (funct_illegal) begin
                    Illegal_Instr = 1'b1;
                    state_d       = StFetch;
                end else begin
                    state_d = StAluWb;
                end
            end
            StAluWb: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                state_d  = StFetch;
            end
            StBranch: begin
                ALUSrcA = 1'b1;
                PCSrc   = 2'b01;
                branch  = 1'b1;
                state_d = StFetch;
            end
            StAddiEx: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = StAddiWb;
            end
            StAddiWb: begin
                RegWrite = 1'b1;
                state_d  = StFetch;
            end
            StJump: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
                state_d  = StFetch;
            end
            default: state_d = StFetch;
        endcase

        PCEn = pc_write | (branch & Zero_flag);

        // Reset overrides everything, abandoning any stalled access.
        if (RST) begin
            state_d       = StFetch;
            Mem_Req       = 1'b0;
            IorD          = 1'b0;
            MemWrite      = 1'b0;
            IRWrite       = 1'b0;
            PCEn          = 1'b0;
            PCSrc         = 2'b00;
            ALUSrcA       = 1'b0;
            ALUSrcB       = 2'b00;
            ALUControl    = '0;
            RegDst        = 1'b0;
            MemtoReg      = 1'b0;
            RegWrite      = 1'b0;
            Illegal_Instr = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: per-cycle expected
// outputs are queued as stimulus is driven and compared at the falling edge.
module tb_multicycle_control_unit;

    logic       CLK, RST, Zero_flag, Mem_Ready;
    logic [5:0] Opcode, Funct;
    logic       Mem_Req, IorD, MemWrite, IRWrite, PCEn, ALUSrcA;
    logic [1:0] PCSrc, ALUSrcB;
    logic [2:0] ALUControl;
    logic       RegDst, MemtoReg, RegWrite, Illegal_Instr;

    multicycle_control_unit dut (
        .CLK           (CLK),
        .RST           (RST),
        .Opcode        (Opcode),
        .Funct         (Funct),
        .Zero_flag     (Zero_flag),
        .Mem_Ready     (Mem_Ready),
        .Mem_Req       (Mem_Req),
        .IorD          (IorD),
        .MemWrite      (MemWrite),
        .IRWrite       (IRWrite),
        .PCEn          (PCEn),
        .PCSrc         (PCSrc),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .ALUControl    (ALUControl),
        .RegDst        (RegDst),
        .MemtoReg      (MemtoReg),
        .RegWrite      (RegWrite),
        .Illegal_Instr (Illegal_Instr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       pc_en;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctl;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       illegal;
    } outs_t;

    localparam int S_RST = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADR = 3, S_MEMREAD = 4;
    localparam int S_MEMWB = 5, S_MEMWRITE = 6, S_EXECUTE = 7, S_ALUWB = 8, S_BRANCH = 9;
    localparam int S_ADDIEX = 10, S_ADDIWB = 11, S_JUMP = 12;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_RILL = 3, K_BEQ = 4, K_ADDI = 5;
    localparam int K_J = 6, K_ILLOP = 7;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       zero;
        int         fstall;
        int         mstall;
        int         kind;
        logic [2:0] alu;
    } vec_t;

    logic [17:0] exp_q[$];
    logic [17:0] mask_q[$];
    string       name_q[$];
    int          errors = 0;
    int          checks = 0;
    vec_t        vecs[14];
    string       vnames[14];

    function automatic string st_name(input int st);
        case (st)
            S_RST:      return "RESET";
            S_FETCH:    return "FETCH";
            S_DECODE:   return "DECODE";
            S_MEMADR:   return "MEMADR";
            S_MEMREAD:  return "MEMREAD";
            S_MEMWB:    return "MEMWB";
            S_MEMWRITE: return "MEMWRITE";
            S_EXECUTE:  return "EXECUTE";
            S_ALUWB:    return "ALUWB";
            S_BRANCH:   return "BRANCH";
            S_ADDIEX:   return "ADDIEX";
            S_ADDIWB:   return "ADDIWB";
            default:    return "JUMP";
        endcase
    endfunction

    // Expected outputs for one cycle; mask marks the fields that are defined.
    function automatic void expect_out(input int st, input logic rdy, input logic zero,
                                       input logic [2:0] alu, input logic ill,
                                       output outs_t e, output outs_t m);
        e = '0;
        m = '0;
        m.mem_req = 1'b1; m.mem_write = 1'b1; m.ir_write = 1'b1;
        m.pc_en = 1'b1; m.reg_write = 1'b1; m.illegal = 1'b1;
        case (st)
            S_RST: m = '1;
            S_FETCH: begin
                e.mem_req = 1'b1; e.ir_write = rdy; e.pc_en = rdy;
                e.alu_src_b = 2'b01; e.alu_ctl = 3'b010;
                m.iord = 1'b1; m.alu_src_a = 1'b1; m.alu_src_b = '1;
                m.alu_ctl = '1; m.pc_src = '1;
            end
            S_DECODE: begin
                e.alu_src_b = 2'b11; e.alu_ctl = 3'b010; e.illegal = ill;
                m.alu_src_a = 1'b1; m.alu_src_b = '1; m.alu_ctl = '1;
            end
            S_MEMADR, S_ADDIEX: begin
                e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_ctl = 3'b010;
                m.alu_src_a = 1'b1; m.alu_src_b = '1; m.alu_ctl = '1;
            end
            S_MEMREAD: begin
                e.mem_req = 1'b1; e.iord = 1'b1; m.iord = 1'b1;
            end
            S_MEMWB: begin
                e.mem_to_reg = 1'b1; e.reg_write = 1'b1;
                m.reg_dst = 1'b1; m.mem_to_reg = 1'b1;
            end
            S_MEMWRITE: begin
                e.mem_req = 1'b1; e.iord = 1'b1; e.mem_write = 1'b1; m.iord = 1'b1;
            end
            S_EXECUTE: begin
                e.alu_src_a = 1'b1; e.alu_ctl = alu; e.illegal = ill;
                m.alu_src_a = 1'b1; m.alu_src_b = '1;
                if (!ill) m.alu_ctl = '1;
            end
            S_ALUWB: begin
                e.reg_dst = 1'b1; e.reg_write = 1'b1;
                m.reg_dst = 1'b1; m.mem_to_reg = 1'b1;
            end
            S_BRANCH: begin
                e.alu_src_a = 1'b1; e.alu_ctl = 3'b110; e.pc_src = 2'b01; e.pc_en = zero;
                m.alu_src_a = 1'b1; m.alu_src_b = '1; m.alu_ctl = '1; m.pc_src = '1;
            end
            S_ADDIWB: begin
                e.reg_write = 1'b1; m.reg_dst = 1'b1; m.mem_to_reg = 1'b1;
            end
            default: begin
                e.pc_src = 2'b10; e.pc_en = 1'b1; m.pc_src = '1;
            end
        endcase
    endfunction

    task automatic check_one();
        logic [17:0] a, e, m;
        string       n;
        a = {Mem_Req, IorD, MemWrite, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB,
             ALUControl, RegDst, MemtoReg, RegWrite, Illegal_Instr};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: got empty queue, want an expected entry");
            return;
        end
        e = exp_q.pop_front();
        m = mask_q.pop_front();
        n = name_q.pop_front();
        if (((a ^ e) & m) != 18'd0) begin
            errors++;
            $display("FAIL %s: got %b want %b (mask %b)", n, a, e, m);
        end
    endtask

    // One clock cycle: drive, queue expectation, sample at negedge.
    task automatic step(input int st, input logic rdy, input logic zero,
                        input logic [2:0] alu, input logic ill, input string iname);
        outs_t e, m;
        Mem_Ready = rdy;
        Zero_flag = zero;
        expect_out(st, rdy, zero, alu, ill, e, m);
        exp_q.push_back(e);
        mask_q.push_back(m);
        name_q.push_back({iname, "/", st_name(st)});
        @(negedge CLK);
        check_one();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_instr(input vec_t v, input string n);
        Opcode = v.op;
        Funct  = v.fn;
        for (int i = 0; i < v.fstall; i++) step(S_FETCH, 1'b0, v.zero, 3'b010, 1'b0, n);
        step(S_FETCH, 1'b1, v.zero, 3'b010, 1'b0, n);
        step(S_DECODE, 1'b1, v.zero, 3'b010, v.kind == K_ILLOP, n);
        case (v.kind)
            K_LW: begin
                step(S_MEMADR, 1'b1, v.zero, 3'b010, 1'b0, n);
                for (int i = 0; i < v.mstall; i++) step(S_MEMREAD, 1'b0, v.zero, 3'b010, 1'b0, n);
                step(S_MEMREAD, 1'b1, v.zero, 3'b010, 1'b0, n);
                step(S_MEMWB, 1'b1, v.zero, 3'b010, 1'b0, n);
            end
            K_SW: begin
                step(S_MEMADR, 1'b1, v.zero, 3'b010, 1'b0, n);
                for (int i = 0; i < v.mstall; i++) step(S_MEMWRITE, 1'b0, v.zero, 3'b010, 1'b0, n);
                step(S_MEMWRITE, 1'b1, v.zero, 3'b010, 1'b0, n);
            end
            K_R: begin
                step(S_EXECUTE, 1'b1, v.zero, v.alu, 1'b0, n);
                step(S_ALUWB, 1'b1, v.zero, 3'b010, 1'b0, n);
            end
            K_RILL:  step(S_EXECUTE, 1'b1, v.zero, 3'b000, 1'b1, n);
            K_BEQ:   step(S_BRANCH, 1'b1, v.zero, 3'b110, 1'b0, n);
            K_ADDI: begin
                step(S_ADDIEX, 1'b1, v.zero, 3'b010, 1'b0, n);
                step(S_ADDIWB, 1'b1, v.zero, 3'b010, 1'b0, n);
            end
            K_J:     step(S_JUMP, 1'b1, v.zero, 3'b010, 1'b0, n);
            default: ;
        endcase
    endtask

    initial begin
        vecs[0]  = '{6'b100011, 6'b000000, 1'b0, 0, 0, K_LW,    3'b010}; vnames[0]  = "lw";
        vecs[1]  = '{6'b101011, 6'b000000, 1'b0, 0, 3, K_SW,    3'b010}; vnames[1]  = "sw_stall3";
        vecs[2]  = '{6'b000000, 6'b101010, 1'b0, 0, 0, K_R,     3'b111}; vnames[2]  = "r_slt";
        vecs[3]  = '{6'b000000, 6'b100000, 1'b0, 0, 0, K_R,     3'b010}; vnames[3]  = "r_add";
        vecs[4]  = '{6'b000000, 6'b100010, 1'b1, 0, 0, K_R,     3'b110}; vnames[4]  = "r_sub";
        vecs[5]  = '{6'b000000, 6'b100100, 1'b0, 0, 0, K_R,     3'b000}; vnames[5]  = "r_and";
        vecs[6]  = '{6'b000000, 6'b100101, 1'b0, 0, 0, K_R,     3'b001}; vnames[6]  = "r_or";
        vecs[7]  = '{6'b000000, 6'b111111, 1'b0, 0, 0, K_RILL,  3'b000}; vnames[7]  = "r_badfunct";
        vecs[8]  = '{6'b000100, 6'b000000, 1'b1, 0, 0, K_BEQ,   3'b110}; vnames[8]  = "beq_taken";
        vecs[9]  = '{6'b000100, 6'b000000, 1'b0, 0, 0, K_BEQ,   3'b110}; vnames[9]  = "beq_not";
        vecs[10] = '{6'b001000, 6'b000000, 1'b0, 0, 0, K_ADDI,  3'b010}; vnames[10] = "addi";
        vecs[11] = '{6'b000010, 6'b000000, 1'b1, 0, 0, K_J,     3'b010}; vnames[11] = "j";
        vecs[12] = '{6'b111111, 6'b000000, 1'b0, 0, 0, K_ILLOP, 3'b010}; vnames[12] = "bad_opcode";
        vecs[13] = '{6'b100011, 6'b000000, 1'b0, 2, 1, K_LW,    3'b010}; vnames[13] = "lw_stalls";

        RST       = 1'b1;
        Mem_Ready = 1'b1;
        Zero_flag = 1'b1;
        Opcode    = 6'b000010;
        Funct     = 6'b000000;
        @(posedge CLK);
        #1;
        // Two reset cycles: enables forced low even with Mem_Ready and Zero_flag high.
        step(S_RST, 1'b1, 1'b1, 3'b000, 1'b0, "reset");
        step(S_RST, 1'b1, 1'b1, 3'b000, 1'b0, "reset");
        RST = 1'b0;

        for (int i = 0; i < 14; i++) run_instr(vecs[i], vnames[i]);

        // Reset during a MEMREAD stall abandons the load without any RegWrite.
        Opcode = 6'b100011;
        Funct  = 6'b000000;
        step(S_FETCH, 1'b1, 1'b0, 3'b010, 1'b0, "lw_abort");
        step(S_DECODE, 1'b1, 1'b0, 3'b010, 1'b0, "lw_abort");
        step(S_MEMADR, 1'b1, 1'b0, 3'b010, 1'b0, "lw_abort");
        step(S_MEMREAD, 1'b0, 1'b0, 3'b010, 1'b0, "lw_abort");
        step(S_MEMREAD, 1'b0, 1'b0, 3'b010, 1'b0, "lw_abort");
        RST = 1'b1;
        step(S_RST, 1'b1, 1'b0, 3'b000, 1'b0, "lw_abort");
        RST = 1'b0;
        run_instr(vecs[11], "j_after_abort");
        run_instr(vecs[10], "addi_final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Moore-style control FSM that sequences a multicycle version of the 32-bit MIPS datapath. A single ALU and a single unified memory are reused across Fetch, Decode, Execute, Memory and Writeback steps. The block decodes opcode/funct and drives every mux select, write enable and ALUControl of the datapath. Memory accesses use a ready handshake so variable-latency memory can stall the sequence.

Parameters:
OPCODE_WIDTH, 6, width of instr[31:26]
FUNCT_WIDTH, 6, width of instr[5:0]
ALUControl_WIDTH, 3, width of ALUControl output

Ports:
CLK  input  1  single clock, rising edge
RST  input  1  synchronous, active-high reset
Opcode  input  6  instr[31:26] from instruction register
Funct  input  6  instr[5:0] from instruction register
Zero_flag  input  1  ALU zero flag
Mem_Ready  input  1  memory completes current access this cycle
Mem_Req  output  1  memory access in progress
IorD  output  1  0=PC addresses memory, 1=ALUOut
MemWrite  output  1  memory write strobe
IRWrite  output  1  load instruction register
PCEn  output  1  PC load = PCWrite | (Branch & Zero_flag)
PCSrc  output  2  00=ALUResult, 01=ALUOut, 10=jump target
ALUSrcA  output  1  0=PC, 1=register A
ALUSrcB  output  2  00=reg B, 01=const 4, 10=SignImm, 11=SignImm<<2
ALUControl  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
RegDst  output  1  0=rt, 1=rd
MemtoReg  output  1  0=ALUOut, 1=memory data
RegWrite  output  1  register file write enable
Illegal_Instr  output  1  one-cycle pulse on unsupported opcode/funct

Behaviour:
- Reset: RST=1 at a rising edge sets state to FETCH. While RST=1, all write enables (MemWrite, IRWrite, PCEn, RegWrite), Mem_Req and Illegal_Instr are forced to 0. Mux selects are don't-care but are driven to 0. RST takes priority over any in-flight access: a stalled access is abandoned.
- States (4-bit encoding): FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- FETCH: Mem_Req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, add, PCSrc=00. IRWrite and PCEn are asserted only in the cycle Mem_Ready=1; the FSM then goes to DECODE, otherwise it stays in FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=11, add (branch target into ALUOut). Next state by opcode:
  - lw 100011 or sw 101011 -> MEMADR
  - R-type 000000 -> EXECUTE
  - beq 000100 -> BRANCH
  - addi 001000 -> ADDIEX
  - j 000010 -> JUMP
  - any other opcode: pulse Illegal_Instr and go to FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, add. Next is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: Mem_Req=1, IorD=1. Holds until Mem_Ready, then goes to MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, then FETCH.
- MEMWRITE: Mem_Req=1, IorD=1, MemWrite=1 every cycle until Mem_Ready, then FETCH. Address and data stay stable throughout.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Any other funct pulses Illegal_Instr, suppresses ALUWB, and goes to FETCH.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, Branch=1, so PCEn=Zero_flag. Then FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, add, then ADDIWB. ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, then FETCH.
- JUMP: PCSrc=10, PCEn=1, then FETCH.
- Cycle counts with Mem_Ready tied high: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each wait state adds exactly one cycle. No write enable is asserted for more than one cycle, except MemWrite during a stall.
- PCEn and IRWrite are combinational from state, Mem_Ready and Zero_flag. All other outputs are Moore outputs of state.

Decomposition:
- Shared package mips_ctrl_pkg holds: state enum, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J), funct constants, ALUControl codes, and ALUOp encoding (00 add, 01 sub, 10 funct).
- One sub-module, alu_decoder: ALUOp + Funct -> ALUControl + funct_illegal. It is combinational and reused by the FSM.

Test Plan:
- RST=1 for 2 cycles, then release, Mem_Ready=1 -> all enables 0 during reset. First post-reset cycle is FETCH with IRWrite=1, PCEn=1, ALUSrcB=01, ALUControl=010.
- lw (Opcode=100011), Mem_Ready=1 -> state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB. RegWrite=1 with MemtoReg=1 and RegDst=0 only in cycle 5.
- sw with Mem_Ready low for 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles, IorD=1 held, return to FETCH on the 4th cycle. No RegWrite occurs.
- beq twice, Zero_flag=1 then Zero_flag=0 -> PCEn=1 with PCSrc=01 in BRANCH for the first, PCEn=0 for the second. Each takes 3 cycles.
- R-type with Funct=101010 -> ALUControl=111 in EXECUTE, then RegWrite=1 with RegDst=1. Funct=111111 -> Illegal_Instr pulses one cycle, no RegWrite, back to FETCH.
- RST asserted mid-MEMREAD stall -> next cycle is FETCH and no RegWrite is ever asserted for the aborted lw. Opcode=111111 in DECODE -> Illegal_Instr pulses and the FSM returns to FETCH.
